// File: rtl/jpeg_pkg.sv
// rtl/jpeg_pkg.sv - shared constants, token type and unstuffer state for the JPEG entropy path
//
// Purpose: definitions imported by jpeg_byte_unstuff and jpeg_tok_fifo.
// Ports:   none (package).
package jpeg_pkg;

  localparam logic [7:0] JPEG_FF    = 8'hFF;
  localparam logic [7:0] JPEG_STUFF = 8'h00;
  localparam logic [7:0] RST_BASE   = 8'hD0;
  localparam logic [7:0] EOI        = 8'hD9;

  // Token as seen by the Huffman decoder: byte, marker flag, end-of-stream flag.
  typedef struct packed {
    logic [7:0] d;
    logic       m;
    logic       e;
  } tok_t;

  typedef enum logic {
    NORM   = 1'b0,
    SAW_FF = 1'b1
  } state_t;

  // True for bytes that form a marker when they follow 0xFF.
  function automatic logic is_marker_code(input logic [7:0] b);
    return (b != JPEG_STUFF) && (b != JPEG_FF);
  endfunction

endpackage

// File: rtl/jpeg_tok_fifo.sv
// rtl/jpeg_tok_fifo.sv - DEPTH x 10 register FIFO with dual push and single pop
//
// Purpose: holds unstuffed tokens; push1 is written in the slot after push0
//          so that two tokens can be queued in one cycle in order.
// Ports:
//   clock, reset (async active-low)
//   push0/push0_tok, push1/push1_tok : writes, push1 only meaningful with push0
//   pop                              : remove head (caller guarantees non-empty)
//   head                             : token at the read pointer
//   count                            : current occupancy
import jpeg_pkg::*;

module jpeg_tok_fifo #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push0,
  input  tok_t          push0_tok,
  input  logic          push1,
  input  tok_t          push1_tok,
  input  logic          pop,
  output tok_t          head,
  output logic [CW-1:0] count
);

  tok_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push0) begin
        mem[wr_ptr] <= push0_tok;
      end
      if (push1) begin
        mem[wr_ptr + AW'(1)] <= push1_tok;
      end
      // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

endmodule

// File: rtl/jpeg_byte_unstuff.sv
// rtl/jpeg_byte_unstuff.sv - strips JPEG byte stuffing and tags markers from the Huffin byte stream
//
// Purpose: 0xFF 0x00 -> 0xFF data, 0xFF fill bytes dropped, 0xFF X -> marker X.
//          Output is registered through jpeg_tok_fifo (one cycle latency).
// Optional: JPEG_UNSTUFF_STATS_EN adds stuff_cnt / mark_cnt counters.
// Ports:
//   clock, reset (async active-low)
//   in_d, in_e, in_v, in_b    : input token, EOS flag, valid, back-pressure
//   out_d, out_m, out_e, out_v: output byte/marker code, marker, EOS, valid
//   out_b                     : downstream back-pressure
//   stuff_cnt, mark_cnt       : saturating statistics (optional)
import jpeg_pkg::*;

module jpeg_byte_unstuff #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in_d,
  input  logic         in_e,
  input  logic         in_v,
  output logic         in_b,
  output logic [W-1:0] out_d,
  output logic         out_m,
  output logic         out_e,
  output logic         out_v,
  input  logic         out_b
`ifdef JPEG_UNSTUFF_STATS_EN
  ,
  output logic [15:0]  stuff_cnt,
  output logic [15:0]  mark_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t          state;
  state_t          state_n;
  logic            accept;
  logic            pop;
  logic            push0;
  logic            push1;
  tok_t            tok0;
  tok_t            tok1;
  tok_t            head;
  logic [CW-1:0]   count;

  // Accepting only while at most DEPTH-2 entries are held leaves room for the
  // two-token EOS-after-FF case without looking at pops this cycle.
  assign in_b   = !reset || (count > CW'(DEPTH - 2));
  assign accept = in_v && !in_b;
  assign out_v  = (count != '0);
  assign pop    = out_v && !out_b;

  // Gate the head so stale storage never shows while empty.
  assign out_d  = out_v ? head.d : '0;
  assign out_m  = out_v & head.m;
  assign out_e  = out_v & head.e;

  always_comb begin
    state_n = state;
    push0   = 1'b0;
    push1   = 1'b0;
    tok0    = '0;
    tok1    = '0;
    if (accept) begin
      case (state)
        NORM: begin
          if (in_e) begin
            push0 = 1'b1;
            tok0  = '{d: 8'h00, m: 1'b0, e: 1'b1};
          end else if (in_d == JPEG_FF) begin
            state_n = SAW_FF;
          end else begin
            push0 = 1'b1;
            tok0  = '{d: in_d, m: 1'b0, e: 1'b0};
          end
        end
        SAW_FF: begin
          if (in_e) begin
            // Dangling 0xFF before EOS is passed on as data, then the EOS.
            push0   = 1'b1;
            tok0    = '{d: JPEG_FF, m: 1'b0, e: 1'b0};
            push1   = 1'b1;
            tok1    = '{d: 8'h00, m: 1'b0, e: 1'b1};
            state_n = NORM;
          end else if (in_d == JPEG_STUFF) begin
            push0   = 1'b1;
            tok0    = '{d: JPEG_FF, m: 1'b0, e: 1'b0};
            state_n = NORM;
          end else if (is_marker_code(in_d)) begin
            push0   = 1'b1;
            tok0    = '{d: in_d, m: 1'b1, e: 1'b0};
            state_n = NORM;
          end
          // else: 0xFF fill byte, stay in SAW_FF with nothing pushed
        end
        default: state_n = NORM;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= NORM;
    end else begin
      state <= state_n;
    end
  end

  jpeg_tok_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push0     (push0),
    .push0_tok (tok0),
    .push1     (push1),
    .push1_tok (tok1),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

`ifdef JPEG_UNSTUFF_STATS_EN
  logic eos_pushed;
  logic stuff_hit;
  logic mark_hit;

  assign eos_pushed = (push0 && tok0.e) || (push1 && tok1.e);
  assign stuff_hit  = accept && (state == SAW_FF) && !in_e && (in_d == JPEG_STUFF);
  assign mark_hit   = push0 && tok0.m;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stuff_cnt <= '0;
      mark_cnt  <= '0;
    end else if (eos_pushed) begin
      stuff_cnt <= '0;
      mark_cnt  <= '0;
    end else begin
      if (stuff_hit && (stuff_cnt != 16'hFFFF)) begin
        stuff_cnt <= stuff_cnt + 16'd1;
      end
      if (mark_hit && (mark_cnt != 16'hFFFF)) begin
        mark_cnt <= mark_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_jpeg_byte_unstuff.sv
// tb/tb_jpeg_byte_unstuff.sv - directed self-checking bench for jpeg_byte_unstuff
module tb_jpeg_byte_unstuff;

  logic       clock;
  logic       reset;
  logic [7:0] in_d;
  logic       in_e;
  logic       in_v;
  logic       in_b;
  logic [7:0] out_d;
  logic       out_m;
  logic       out_e;
  logic       out_v;
  logic       out_b;
`ifdef JPEG_UNSTUFF_STATS_EN
  logic [15:0] stuff_cnt;
  logic [15:0] mark_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];

  jpeg_byte_unstuff #(.W(8), .DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .in_d  (in_d),
    .in_e  (in_e),
    .in_v  (in_v),
    .in_b  (in_b),
    .out_d (out_d),
    .out_m (out_m),
    .out_e (out_e),
    .out_v (out_v),
    .out_b (out_b)
`ifdef JPEG_UNSTUFF_STATS_EN
    ,
    .stuff_cnt (stuff_cnt),
    .mark_cnt  (mark_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every output transfer; out_b only changes after posedge so the
  // negedge sample matches what the next edge will do.
  always @(negedge clock) begin
    if (reset && out_v && !out_b) begin
      got_q.push_back({out_d, out_m, out_e});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic e);
    int n = 0;
    in_d = d;
    in_e = e;
    in_v = 1'b1;
    @(negedge clock);
    while (in_b && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (in_b) check_eq("send_timeout", 32'(in_b), 32'd0);
    @(posedge clock);
    #1;
    in_v = 1'b0;
    in_d = 8'h00;
    in_e = 1'b0;
  endtask

  task automatic drain_and_compare(input string tag);
    repeat (8) @(posedge clock);
    #1;
    check_eq($sformatf("%s_len", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0;
    in_d  = 8'h00;
    in_e  = 1'b0;
    in_v  = 1'b0;
    out_b = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_out_v", 32'(out_v), 32'd0);
    check_eq("rst_out_d", 32'(out_d), 32'd0);
    check_eq("rst_out_me", 32'({out_m, out_e}), 32'd0);
    check_eq("rst_in_b", 32'(in_b), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("rel_in_b", 32'(in_b), 32'd0);
    @(posedge clock);
    #1;

    // Stuffed pair in a plain stream; also first-token latency.
    send(8'h12, 1'b0);
    check_eq("lat_out_v", 32'(out_v), 32'd1);
    check_eq("lat_out_d", 32'(out_d), 32'h12);
    send(8'h34, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    send(8'h56, 1'b0);
    exp_q = '{{8'h12, 2'b00}, {8'h34, 2'b00}, {8'hFF, 2'b00}, {8'h56, 2'b00}};
    drain_and_compare("stuff");

    // Fill bytes then a restart marker.
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hD3, 1'b0);
    exp_q = '{{8'hD3, 2'b10}};
    drain_and_compare("fill");

    // Dangling FF followed by EOS.
    send(8'hAB, 1'b0);
    send(8'hFF, 1'b0);
    check_eq("pre_eos_in_b", 32'(in_b), 32'd0);
    send(8'h00, 1'b1);
    exp_q = '{{8'hAB, 2'b00}, {8'hFF, 2'b00}, {8'h00, 2'b01}};
    drain_and_compare("ff_eos");

    // Back-pressure: three accepts fill to the threshold.
    out_b = 1'b1;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    check_eq("bp_in_b_cnt2", 32'(in_b), 32'd0);
    send(8'h03, 1'b0);
    check_eq("bp_in_b_cnt3", 32'(in_b), 32'd1);
    check_eq("bp_head0", 32'(out_d), 32'h01);
    repeat (7) @(posedge clock);
    #1;
    check_eq("bp_hold_v", 32'(out_v), 32'd1);
    check_eq("bp_hold_d", 32'(out_d), 32'h01);
    check_eq("bp_hold_in_b", 32'(in_b), 32'd1);
    out_b = 1'b0;
    for (int i = 4; i <= 8; i++) send(8'(i), 1'b0);
    for (int i = 1; i <= 8; i++) exp_q.push_back({8'(i), 2'b00});
    drain_and_compare("bp");

    // Reset right after a pending FF.
    out_b = 1'b1;
    send(8'h77, 1'b0);
    send(8'hFF, 1'b0);
    check_eq("pre_rst_v", 32'(out_v), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_v", 32'(out_v), 32'd0);
    check_eq("mid_rst_in_b", 32'(in_b), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    out_b = 1'b0;
    got_q.delete();
    @(posedge clock);
    #1;
    send(8'h00, 1'b0);
    exp_q = '{{8'h00, 2'b00}};
    drain_and_compare("post_rst");

`ifdef JPEG_UNSTUFF_STATS_EN
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hD0, 1'b0);
    #1;
    check_eq("stuff_cnt", 32'(stuff_cnt), 32'd2);
    check_eq("mark_cnt", 32'(mark_cnt), 32'd1);
    send(8'h00, 1'b1);
    check_eq("stuff_cnt_clr", 32'(stuff_cnt), 32'd0);
    check_eq("mark_cnt_clr", 32'(mark_cnt), 32'd0);
    exp_q = '{{8'hFF, 2'b00}, {8'hFF, 2'b00}, {8'hD0, 2'b10}, {8'h00, 2'b01}};
    drain_and_compare("stats");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
